add1bit_checker: RTL and testbench

Synthesizable response checker for the 1-bit half-adder `add1bit_half`; it forms the receiving end of the stimulus path. A stimulus source drives `a`/`b` with a valid strobe. The checker computes the golden sum/carry, delays it to match DUT latency, compares it against the DUT's `o`/`c`, and reports a pass/fail verdict with error statistics. It sits beside the DUT in benches and on-chip self-test wrappers.

---
 rtl/add1bit_pkg.sv | 21 ++
 rtl/add1bit_delay_line.sv | 54 +++++
 rtl/add1bit_checker.sv | 129 ++++++++++++
 tb/tb_add1bit_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add1bit_pkg.sv
// Shared types and helpers for the add1bit half-adder response checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package add1bit_pkg;

  // Largest DUT latency the checker's delay line and drain counter are sized for.
  localparam int MAX_DELAY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Golden half-adder response packed as {carry, sum}.
  function automatic logic [1:0] add1bit_golden(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/add1bit_delay_line.sv
// Delays accepted vectors {tag_valid, idx, ab, golden} to line up with DUT latency.
// Latency: DELAY clocks; DELAY=0 is a combinational bypass.
// Backpressure: none; advances every clock and carries bubbles as cleared tags.
module add1bit_delay_line #(
  parameter int DELAY     = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_vld,
  input  logic [CNT_WIDTH-1:0] in_idx,
  input  logic [1:0]           in_ab,
  input  logic [1:0]           in_golden,
  output logic                 out_vld,
  output logic [CNT_WIDTH-1:0] out_idx,
  output logic [1:0]           out_ab,
  output logic [1:0]           out_golden
);

  // One stage is kept even for DELAY=0 so the array is never empty; it is dead
  // logic in that case because the output takes the bypass path.
  localparam int DEPTH = (DELAY == 0) ? 1 : DELAY;

  typedef struct packed {
    logic                 vld;
    logic [CNT_WIDTH-1:0] idx;
    logic [1:0]           ab;
    logic [1:0]           golden;
  } entry_t;

  entry_t in_ent;
  entry_t out_ent;
  entry_t stage [DEPTH];

  assign in_ent = {in_vld, in_idx, in_ab, in_golden};

  // Shift every clock; reset clears the tags so no stale compare can fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_ent;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_ent = (DELAY == 0) ? in_ent : stage[DEPTH-1];
  assign {out_vld, out_idx, out_ab, out_golden} = out_ent;

endmodule

// File: rtl/add1bit_checker.sv
// Response checker for add1bit_half: golden compare, error count, first-fail capture.
// Latency: compare DELAY clocks after accept; counters/verdict registered one edge later.
// Backpressure: none; valid is sampled only in RUN, start only in IDLE/DONE.
module add1bit_checker
  import add1bit_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int DELAY       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 valid,
  input  logic                 a,
  input  logic                 b,
  input  logic                 o,
  input  logic                 c,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] vec_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] first_fail_idx,
  output logic [1:0]           first_fail_ab
);

  // DELAY is expected within 0..MAX_DELAY; the drain counter is 2 bits wide.
  localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(NUM_VECTORS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [1:0]           DRAIN_LOAD = (DELAY > 0) ? 2'(DELAY - 1) : 2'd0;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             drain_cnt;

  logic                   accept;
  logic                   run_start;
  logic                   last_accept;
  logic [1:0]             acc_golden;

  logic                   cmp_vld;
  logic [CNT_WIDTH-1:0]   cmp_idx;
  logic [1:0]             cmp_ab;
  logic [1:0]             cmp_golden;
  logic                   mismatch;

  assign accept      = (state == ST_RUN) && valid;
  assign run_start   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_accept = accept && (vec_count == LAST_IDX);
  assign acc_golden  = add1bit_golden(a, b);

  add1bit_delay_line #(
    .DELAY     (DELAY),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_delay_line (
    .clk        (clk),
    .reset      (reset),
    .in_vld     (accept),
    .in_idx     (vec_count),
    .in_ab      ({a, b}),
    .in_golden  (acc_golden),
    .out_vld    (cmp_vld),
    .out_idx    (cmp_idx),
    .out_ab     (cmp_ab),
    .out_golden (cmp_golden)
  );

  // DUT response is only looked at when a tagged entry is due.
  assign mismatch = cmp_vld && ({c, o} != cmp_golden);

  // Next-state: run on start, drain outstanding compares, then hold the verdict.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run_start) state_nxt = ST_RUN;
      ST_RUN:   if (last_accept) state_nxt = (DELAY > 0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (drain_cnt == 2'd0) state_nxt = ST_DONE;
      ST_DONE:  if (run_start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register plus drain countdown armed on the final accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (last_accept) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == ST_DRAIN) && (drain_cnt != 2'd0)) begin
        drain_cnt <= drain_cnt - 2'd1;
      end
    end
  end

  // Run statistics: cleared by an accepted start, first mismatch latched once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_ab  <= 2'b00;
    end else if (run_start) begin
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_ab  <= 2'b00;
    end else begin
      if (accept) begin
        vec_count <= vec_count + CNT_ONE;
      end
      if (mismatch) begin
        err_count <= err_count + CNT_ONE;
        if (err_count == '0) begin
          first_fail_idx <= cmp_idx;
          first_fail_ab  <= cmp_ab;
        end
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_add1bit_checker.sv
// Bench for add1bit_checker: DELAY=0 and DELAY=2 instances with reference DUT models.
// Latency: n/a.
// Backpressure: n/a.
module tb_add1bit_checker;

  localparam int CW = 8;

  typedef struct {
    int vec;
    int err;
    int ffi;
    int ffab;
    int pass;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic valid;
  logic a;
  logic b;
  logic stuck_o;
  logic flip_c;

  logic o0, c0, o2, c2;
  logic [1:0] dut2_r1, dut2_r2;

  logic busy0, done0, pass0;
  logic [CW-1:0] vec0, err0, ffi0;
  logic [1:0] ffab0;
  logic busy2, done2, pass2;
  logic [CW-1:0] vec2, err2, ffi2;
  logic [1:0] ffab2;

  int n_tests = 0;
  int n_fail  = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  // Combinational half adder with fault hooks.
  assign o0 = stuck_o ? 1'b0 : (a ^ b);
  assign c0 = (a & b) ^ flip_c;

  // Half adder registered twice.
  always @(posedge clk) begin
    dut2_r1 <= {a & b, a ^ b};
    dut2_r2 <= dut2_r1;
  end
  assign o2 = dut2_r2[0];
  assign c2 = dut2_r2[1];

  add1bit_checker #(.NUM_VECTORS(4), .CNT_WIDTH(CW), .DELAY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .a(a), .b(b),
    .o(o0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vec0), .err_count(err0), .first_fail_idx(ffi0), .first_fail_ab(ffab0)
  );

  add1bit_checker #(.NUM_VECTORS(4), .CNT_WIDTH(CW), .DELAY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .a(a), .b(b),
    .o(o2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec2), .err_count(err2), .first_fail_idx(ffi2), .first_fail_ab(ffab2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done, then pop the expected verdict and compare.
  task automatic check_result(input bit use2, input string tag);
    res_t e;
    int n;
    n = 0;
    while (((use2 ? done2 : done0) !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, ".done"}, use2 ? done2 : done0, 1);
    check({tag, ".sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({tag, ".busy"}, use2 ? busy2 : busy0, 0);
    check({tag, ".vec"},  use2 ? vec2  : vec0,  e.vec);
    check({tag, ".err"},  use2 ? err2  : err0,  e.err);
    check({tag, ".ffi"},  use2 ? ffi2  : ffi0,  e.ffi);
    check({tag, ".ffab"}, use2 ? ffab2 : ffab0, e.ffab);
    check({tag, ".pass"}, use2 ? pass2 : pass0, e.pass);
  endtask

  // Full 4-vector run on the DELAY=0 instance; vector i is vecs[2i+:2] as {a,b}.
  task automatic run0(input logic [7:0] vecs, input bit stuck, input int flip_idx,
                      input logic [3:0] start_mask, input string tag);
    res_t e;
    logic [1:0] ab;
    logic go, gc, dout, dc;
    e = '{vec: 4, err: 0, ffi: 0, ffab: 0, pass: 0};
    for (int i = 0; i < 4; i++) begin
      ab   = vecs[2*i +: 2];
      go   = ab[1] ^ ab[0];
      gc   = ab[1] & ab[0];
      dout = stuck ? 1'b0 : go;
      dc   = gc ^ (i == flip_idx);
      if ((dout != go) || (dc != gc)) begin
        if (e.err == 0) begin
          e.ffi  = i;
          e.ffab = ab;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    sb_q.push_back(e);

    stuck_o = stuck;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".start_busy"}, busy0, 1);
    check({tag, ".start_done"}, done0, 0);
    check({tag, ".start_pass"}, pass0, 0);
    check({tag, ".start_vec"},  vec0,  0);
    check({tag, ".start_err"},  err0,  0);
    for (int i = 0; i < 4; i++) begin
      valid  = 1'b1;
      {a, b} = vecs[2*i +: 2];
      flip_c = (i == flip_idx);
      start  = start_mask[i];
      tick();
    end
    valid  = 1'b0;
    start  = 1'b0;
    flip_c = 1'b0;
    {a, b} = 2'b00;
    check_result(1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0;
    stuck_o = 1'b0; flip_c = 1'b0;
    tick();
    tick();
    check("rst.busy", busy0, 0);
    check("rst.done", done0, 0);
    check("rst.pass", pass0, 0);
    check("rst.vec",  vec0,  0);
    check("rst.err",  err0,  0);
    check("rst.ffi",  ffi0,  0);
    check("rst.ffab", ffab0, 0);
    check("rst.busy2", busy2, 0);
    reset = 1'b0;
    tick();

    run0(8'b11_01_10_00, 1'b0, -1, 4'b0000, "clean");
    run0(8'b11_01_10_00, 1'b1, -1, 4'b0000, "stuck_o");
    run0(8'b11_01_10_00, 1'b0,  3, 4'b0000, "flip_c3");
    run0(8'b11_01_10_00, 1'b0, -1, 4'b1010, "mid_start");

    // valid while DONE must be ignored
    valid = 1'b1; {a, b} = 2'b11;
    tick();
    tick();
    valid = 1'b0; {a, b} = 2'b00;
    check("done_valid.done", done0, 1);
    check("done_valid.vec",  vec0,  4);
    check("done_valid.busy", busy0, 0);

    run0(8'b00_11_01_10, 1'b0, -1, 4'b0000, "restart");

    // Reset mid-run after two vectors, with errors already counted
    stuck_o = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1; {a, b} = 2'b10;
    tick();
    {a, b} = 2'b01;
    tick();
    check("rst_mid.pre_vec", vec0, 2);
    check("rst_mid.pre_err", err0, 2);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.busy", busy0, 0);
    check("rst_mid.done", done0, 0);
    check("rst_mid.vec",  vec0,  0);
    check("rst_mid.err",  err0,  0);
    check("rst_mid.ffab", ffab0, 0);
    check("rst_mid.busy2", busy2, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    {a, b} = 2'b11;
    tick();
    tick();
    valid = 1'b0;
    stuck_o = 1'b0;
    check("rst_mid.idle_vec",  vec0,  0);
    check("rst_mid.idle_busy", busy0, 0);
    check("rst_mid.idle_done", done0, 0);

    // DELAY=2 run with a one-cycle valid gap after vector 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    sb_q.push_back('{vec: 4, err: 0, ffi: 0, ffab: 0, pass: 1});
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1; {a, b} = 2'b00;
    tick();
    {a, b} = 2'b10;
    tick();
    valid = 1'b0; {a, b} = 2'b11;
    tick();
    valid = 1'b1; {a, b} = 2'b01;
    tick();
    {a, b} = 2'b11;
    tick();
    valid = 1'b0; {a, b} = 2'b10;
    check("d2.e0_done", done2, 0);
    check("d2.e0_busy", busy2, 1);
    tick();
    check("d2.e1_done", done2, 0);
    tick();
    check("d2.e2_done", done2, 1);
    check_result(1'b1, "d2");

    check("sb.empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
